// File: rtl/os_pulse_pkg.sv
// -----------------------------------------------------------------------------
// os_pulse_pkg
// Shared definitions for the delayed-pulse scheduler family:
//   - state_t : scheduler FSM state encoding (IDLE / DELAY / PULSE)
//   - clog2   : elaboration-time ceil(log2) used to size channel indices
// -----------------------------------------------------------------------------
package os_pulse_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  // ceil(log2(v)); returns 0 for v <= 1
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/os_rr_arbiter.sv
// -----------------------------------------------------------------------------
// os_rr_arbiter
// Purely combinational round-robin arbiter. The search starts at the channel
// after i_last and wraps, so the most recently served channel has the lowest
// priority.
// Ports:
//   i_req   [NCH]  request bits
//   i_last  [CHW]  index of the most recently granted channel
//   o_gnt   [NCH]  one-hot grant (all zero when no request)
//   o_idx   [CHW]  index of the granted channel (0 when no request)
//   o_valid        any request present
// -----------------------------------------------------------------------------
module os_rr_arbiter
  import os_pulse_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CHW = clog2(NCH)
) (
  input  logic [NCH-1:0] i_req,
  input  logic [CHW-1:0] i_last,
  output logic [NCH-1:0] o_gnt,
  output logic [CHW-1:0] o_idx,
  output logic           o_valid
);

  // Two passes: channels above i_last first, then wrap to 0..i_last.
  always_comb begin : arb
    logic found;
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!found && i_req[c] && (c > 32'(i_last))) begin
        o_gnt[c] = 1'b1;
        o_idx    = CHW'(c);
        found    = 1'b1;
      end
    end
    for (int unsigned c = 0; c < NCH; c++) begin
      if (!found && i_req[c] && (c <= 32'(i_last))) begin
        o_gnt[c] = 1'b1;
        o_idx    = CHW'(c);
        found    = 1'b1;
      end
    end
  end

  assign o_valid = |i_req;

endmodule

// File: rtl/os_pulse_sched.sv
// -----------------------------------------------------------------------------
// os_pulse_sched
// Multi-channel delayed-pulse scheduler. Rising edges on trig (qualified by
// trig_en) queue one pending request per channel; a round-robin arbiter picks
// a channel when the shared timer is idle, and the timer then produces one
// pulse of max(dur,1) cycles after delay cycles, tagged with the channel.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   trig     [NCH]      per-channel trigger level (rising edge requests)
//   trig_en  [NCH]      per-channel edge enable
//   delay    [NCH*CW]   per-channel delay, channel i at [i*CW +: CW]
//   dur      [NCH*CW]   per-channel pulse length (0 behaves as 1)
//   abort               cancel active slot and all pending requests
//   pulse               registered pulse output
//   pulse_ch [CHW]      channel owning the current slot
//   busy                high while in DELAY or PULSE
//   done     [NCH]      one-cycle strobe when a channel's pulse ends
//   ovf      [NCH]      one-cycle strobe when an edge hits an already pending channel
// -----------------------------------------------------------------------------
module os_pulse_sched
  import os_pulse_pkg::*;
#(
  parameter int unsigned NCH = 4,
  parameter int unsigned CW  = 8,
  parameter int unsigned CHW = clog2(NCH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    trig,
  input  logic [NCH-1:0]    trig_en,
  input  logic [NCH*CW-1:0] delay,
  input  logic [NCH*CW-1:0] dur,
  input  logic              abort,
  output logic              pulse,
  output logic [CHW-1:0]    pulse_ch,
  output logic              busy,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    ovf
);

  // Registered state
  state_t         r_state;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_len;
  logic [NCH-1:0] r_trig_prev;
  logic [NCH-1:0] r_pending;
  logic [CHW-1:0] r_last;
  logic [CHW-1:0] r_pulse_ch;
  logic           r_pulse;
  logic           r_busy;
  logic [NCH-1:0] r_done;
  logic [NCH-1:0] r_ovf;

  // Combinational helpers
  logic [NCH-1:0] w_edge;
  logic [NCH-1:0] w_gnt;
  logic [CHW-1:0] w_gnt_idx;
  logic           w_any;
  logic           w_grant;
  logic [NCH-1:0] w_gnt_mask;
  logic [CW-1:0]  w_sel_delay;
  logic [CW-1:0]  w_sel_dur;
  logic [CW-1:0]  w_sel_len;

  // Qualified rising edges
  assign w_edge = trig & ~r_trig_prev & trig_en;

  os_rr_arbiter #(
    .NCH (NCH),
    .CHW (CHW)
  ) u_arb (
    .i_req   (r_pending),
    .i_last  (r_last),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_any)
  );

  // Grant only from IDLE; abort blocks a grant in the same cycle
  assign w_grant    = (r_state == ST_IDLE) && w_any && !abort;
  assign w_gnt_mask = w_grant ? w_gnt : '0;

  // Config of the winning channel, sampled only at grant
  assign w_sel_delay = delay[32'(w_gnt_idx)*CW +: CW];
  assign w_sel_dur   = dur[32'(w_gnt_idx)*CW +: CW];
  assign w_sel_len   = (w_sel_dur == '0) ? CW'(1) : w_sel_dur;

  // Request queue, edge tracking and slot FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_len       <= '0;
      r_trig_prev <= '0;
      r_pending   <= '0;
      r_last      <= CHW'(NCH - 1);
      r_pulse_ch  <= '0;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= '0;
      r_ovf       <= '0;
    end else begin
      r_trig_prev <= trig;
      r_done      <= '0;
      r_ovf       <= '0;

      if (abort) begin
        // Cancel everything, including edges arriving this cycle
        r_pending <= '0;
        r_state   <= ST_IDLE;
        r_pulse   <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        // New edge wins over grant-clear; an edge is only dropped (ovf)
        // when its channel stays pending
        r_pending <= (r_pending & ~w_gnt_mask) | w_edge;
        r_ovf     <= w_edge & r_pending & ~w_gnt_mask;

        case (r_state)
          ST_IDLE: begin
            if (w_grant) begin
              r_pulse_ch <= w_gnt_idx;
              r_last     <= w_gnt_idx;
              r_len      <= w_sel_len;
              r_busy     <= 1'b1;
              if (w_sel_delay != '0) begin
                r_state <= ST_DELAY;
                r_cnt   <= w_sel_delay;
              end else begin
                r_state <= ST_PULSE;
                r_cnt   <= w_sel_len;
                r_pulse <= 1'b1;
              end
            end
          end

          ST_DELAY: begin
            if (r_cnt == CW'(1)) begin
              r_state <= ST_PULSE;
              r_cnt   <= r_len;
              r_pulse <= 1'b1;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end

          ST_PULSE: begin
            if (r_cnt == CW'(1)) begin
              r_state <= ST_IDLE;
              r_pulse <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= NCH'(1) << r_pulse_ch;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end

          default: begin
            r_state <= ST_IDLE;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pulse    = r_pulse;
  assign pulse_ch = r_pulse_ch;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_os_pulse_sched.sv
// -----------------------------------------------------------------------------
// tb_os_pulse_sched
// Self-checking bench for os_pulse_sched: directed scenarios followed by a
// randomized phase, every cycle compared against a timestamp-based model.
// -----------------------------------------------------------------------------
module tb_os_pulse_sched;

  localparam int unsigned NCH = 4;
  localparam int unsigned CW  = 8;
  localparam int unsigned CHW = 2;

  logic              clk;
  logic              rst_n;
  logic [NCH-1:0]    trig;
  logic [NCH-1:0]    trig_en;
  logic [NCH*CW-1:0] delay;
  logic [NCH*CW-1:0] dur;
  logic              abort;
  logic              pulse;
  logic [CHW-1:0]    pulse_ch;
  logic              busy;
  logic [NCH-1:0]    done;
  logic [NCH-1:0]    ovf;

  os_pulse_sched #(
    .NCH (NCH),
    .CW  (CW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .trig_en  (trig_en),
    .delay    (delay),
    .dur      (dur),
    .abort    (abort),
    .pulse    (pulse),
    .pulse_ch (pulse_ch),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model (slot timestamps) ----------------
  int             n;          // index of the most recent clock edge
  logic [NCH-1:0] m_pend, m_prev, m_done, m_ovf;
  bit             m_act;
  int             m_t, m_d, m_l, m_ch, m_last;
  bit             m_pulse, m_busy;

  task automatic model_reset();
    m_pend = '0; m_prev = '0; m_done = '0; m_ovf = '0;
    m_act = 1'b0; m_t = 0; m_d = 0; m_l = 0; m_ch = 0; m_last = NCH - 1;
    m_pulse = 1'b0; m_busy = 1'b0;
  endtask

  task automatic model_step();
    logic [NCH-1:0] e, gm;
    bit idle;
    int g, slot_end, dv, lv;
    n++;
    e = trig & ~m_prev & trig_en;
    m_prev = trig;
    m_done = '0;
    m_ovf  = '0;
    gm     = '0;
    slot_end = m_t + m_d + m_l;
    if (m_act && n == slot_end && !abort) m_done[m_ch] = 1'b1;
    idle = !m_act || (n > slot_end);
    if (idle) m_act = 1'b0;
    if (abort) begin
      m_pend = '0;
      m_act  = 1'b0;
    end else begin
      if (idle && (m_pend != '0)) begin
        g = -1;
        for (int k = 1; k <= NCH; k++) begin
          int c;
          c = (m_last + k) % NCH;
          if (g < 0 && m_pend[c]) g = c;
        end
        dv = int'(delay[g*CW +: CW]);
        lv = int'(dur[g*CW +: CW]);
        if (lv == 0) lv = 1;
        m_act = 1'b1; m_t = n; m_d = dv; m_l = lv; m_ch = g; m_last = g;
        gm[g] = 1'b1;
      end
      m_ovf  = e & m_pend & ~gm;
      m_pend = (m_pend & ~gm) | e;
    end
    m_pulse = m_act && (n >= m_t + m_d) && (n < m_t + m_d + m_l);
    m_busy  = m_act && (n < m_t + m_d + m_l);
  endtask

  // ---------------- per-scenario observation stats ----------------
  int s_cyc, s_hi, s_done_cnt, s_done_at, s_ovf2;
  bit s_prev_pulse;
  int s_rise_ch[$];
  int s_rise_at[$];

  task automatic stat_clear();
    s_cyc = 0; s_hi = 0; s_done_cnt = 0; s_done_at = -1; s_ovf2 = 0;
    s_rise_ch.delete(); s_rise_at.delete();
  endtask

  // One clock: advance, check against model, collect stats
  task automatic cyc();
    @(posedge clk);
    #1;
    model_step();
    chk("pulse",    32'(pulse),    32'(m_pulse));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("pulse_ch", 32'(pulse_ch), 32'(m_ch));
    chk("done",     32'(done),     32'(m_done));
    chk("ovf",      32'(ovf),      32'(m_ovf));
    if (pulse && !s_prev_pulse) begin
      s_rise_ch.push_back(int'(pulse_ch));
      s_rise_at.push_back(s_cyc);
    end
    if (pulse) s_hi++;
    if (done != '0) begin s_done_cnt++; s_done_at = s_cyc; end
    if (ovf[2]) s_ovf2++;
    s_prev_pulse = pulse;
    s_cyc++;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    trig  = '0;
    #1;
    chk("rst_pulse",    32'(pulse),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_pulse_ch", 32'(pulse_ch), 32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ovf",      32'(ovf),      32'd0);
    model_reset();
    s_prev_pulse = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic set_cfg(input int ch, input int d, input int l);
    delay[ch*CW +: CW] = CW'(d);
    dur[ch*CW +: CW]   = CW'(l);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    bit retrig;
    int ch2_rises;
    rst_n = 1'b0; trig = '0; trig_en = '1; abort = 1'b0; delay = '0; dur = '0;
    n = 0; s_prev_pulse = 1'b0;
    model_reset();
    stat_clear();
    #3;
    chk("rst_pulse",    32'(pulse),    32'd0);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_pulse_ch", 32'(pulse_ch), 32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_ovf",      32'(ovf),      32'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Single request: ch0 delay 3, dur 2
    stat_clear();
    set_cfg(0, 3, 2);
    trig = 4'b0001; cyc();
    trig = '0; repeat (10) cyc();
    chk("single_rises", 32'(s_rise_ch.size()), 32'd1);
    chk("single_rise_at", 32'(qget(s_rise_at, 0)), 32'd4);
    chk("single_ch", 32'(qget(s_rise_ch, 0)), 32'd0);
    chk("single_width", 32'(s_hi), 32'd2);
    chk("single_done_at", 32'(s_done_at), 32'd6);

    // Zero config: 1-cycle pulse right after grant
    stat_clear();
    set_cfg(0, 0, 0);
    trig = 4'b0001; cyc();
    trig = '0; repeat (6) cyc();
    chk("zero_rise_at", 32'(qget(s_rise_at, 0)), 32'd1);
    chk("zero_width", 32'(s_hi), 32'd1);
    chk("zero_done_at", 32'(s_done_at), 32'd2);

    // Contention: ch1 and ch3 together
    stat_clear();
    set_cfg(1, 0, 2); set_cfg(3, 0, 2);
    trig = 4'b1010; cyc();
    trig = '0; repeat (10) cyc();
    chk("cont_first", 32'(qget(s_rise_ch, 0)), 32'd1);
    chk("cont_second", 32'(qget(s_rise_ch, 1)), 32'd3);
    chk("cont_gap", 32'(qget(s_rise_at, 1) - qget(s_rise_at, 0) - 2), 32'd1);

    // Overrun on ch2 while ch0 holds the timer, then re-trigger during ch2 PULSE
    stat_clear();
    set_cfg(0, 4, 1); set_cfg(2, 5, 2);
    trig = 4'b0001; cyc();
    trig = 4'b0101; cyc();
    trig = 4'b0001; cyc();
    trig = 4'b0101; cyc();
    trig = 4'b0000;
    retrig = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (!retrig && pulse && pulse_ch == CHW'(2)) begin
        trig[2] = 1'b1;
        retrig  = 1'b1;
      end
    end
    trig = '0;
    ch2_rises = 0;
    foreach (s_rise_ch[i]) if (s_rise_ch[i] == 2) ch2_rises++;
    chk("ovr_ovf_cnt", 32'(s_ovf2), 32'd1);
    chk("ovr_retrig", 32'(retrig), 32'd1);
    chk("ovr_ch2_pulses", 32'(ch2_rises), 32'd2);

    // Abort mid-DELAY with ch0 and ch2 pending
    set_cfg(1, 8, 2);
    trig = 4'b0010; cyc();
    trig = '0;      cyc();
    trig = 4'b0101; cyc();
    trig = '0;      cyc();
    abort = 1'b1;   cyc();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    stat_clear();
    repeat (25) cyc();
    chk("abort_no_pulse", 32'(s_hi), 32'd0);
    chk("abort_no_done", 32'(s_done_cnt), 32'd0);

    // Async reset mid-PULSE, then priority restart from ch0
    set_cfg(0, 0, 10);
    trig = 4'b0001; cyc();
    trig = '0; repeat (3) cyc();
    chk("rst_mid_pre", 32'(pulse), 32'd1);
    do_reset();
    stat_clear();
    set_cfg(0, 2, 3); set_cfg(3, 0, 1);
    trig = 4'b1001; cyc();
    trig = '0; repeat (12) cyc();
    chk("post_rst_first", 32'(qget(s_rise_ch, 0)), 32'd0);
    chk("post_rst_rise_at", 32'(qget(s_rise_at, 0)), 32'd3);
    chk("post_rst_second", 32'(qget(s_rise_ch, 1)), 32'd3);

    // Edge with enable low is discarded
    stat_clear();
    trig_en = 4'b1101;
    trig = 4'b0010; cyc();
    trig = '0; repeat (10) cyc();
    chk("en_off_pulses", 32'(s_hi), 32'd0);
    trig_en = '1;

    // Randomized phase
    for (int i = 0; i < 2500; i++) begin
      for (int c = 0; c < NCH; c++) begin
        delay[c*CW +: CW] = ($urandom_range(0, 40) == 0) ? CW'($urandom) : CW'($urandom_range(0, 5));
        dur[c*CW +: CW]   = ($urandom_range(0, 40) == 0) ? CW'($urandom) : CW'($urandom_range(0, 4));
      end
      trig    = trig ^ (NCH'($urandom) & NCH'($urandom));
      trig_en = ~(NCH'($urandom) & NCH'($urandom) & NCH'($urandom));
      abort   = ($urandom_range(0, 79) == 0);
      if (i == 1250) begin
        abort = 1'b0;
        do_reset();
      end
      cyc();
    end
    abort = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
